// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared definitions for the data-memory arbiter that sits between the
//   processor's data-memory port and the single-port 4K x 32 data RAM.
//   - Default widths matching the RAM (word address, data).
//   - Default arbitration parameters.
//   - Owner encodings identifying which master a RAM access belongs to.
//   - Helper that sizes the bounded-wait counter.
package dmem_arbiter_pkg;

  localparam int ADDR_W_DEF   = 12;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_WAIT_DEF = 3;
  localparam int CNT_W_DEF    = 16;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_PER  = 2'd2;

  // The wait counter must hold 0..max_wait. A max_wait of 0 still gets a
  // 1-bit register so the counter never collapses to a zero-width vector.
  function automatic int wait_cnt_w(input int max_wait);
    if (max_wait < 1) return 1;
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/arb_wait_ctr.sv
// arb_wait_ctr
//   Bounded-wait counter for the peripheral side of dmem_arbiter. Counts the
//   consecutive cycles a pending peripheral request has lost to the CPU and
//   flags when the peripheral must win the next conflict.
// Ports:
//   clock   in   system clock
//   reset   in   synchronous, active-high reset
//   inc     in   peripheral lost a conflict this cycle
//   clr     in   peripheral was granted or is not requesting
//   at_max  out  counter has reached MAX_WAIT
module arb_wait_ctr
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int W = wait_cnt_w(MAX_WAIT);
  localparam logic [W-1:0] MAX_V = W'(MAX_WAIT);

  logic [W-1:0] wait_cnt;

  // Clear has priority over increment; the increment stops at MAX_V so the
  // counter can never exceed the bound even if inc is held.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      wait_cnt <= '0;
    end else if (inc && (wait_cnt != MAX_V)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign at_max = (wait_cnt == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data RAM between the CPU data-memory port and a
//   synth-side peripheral master (wavetable fetch, MIDI event writer, ...).
//   The CPU wins by default; a bounded-wait counter guarantees the
//   peripheral a slot after MAX_WAIT lost conflicts. When the peripheral
//   takes the slot the CPU is stalled and re-issues its access.
// Ports:
//   clock, reset                       clock, synchronous active-high reset
//   cpu_en/wren/addr/data, cpu_q       CPU data-memory port
//   cpu_stall                          CPU access not serviced this cycle
//   per_req/we/addr/wdata, per_gnt     peripheral request / accept
//   per_rvalid, per_rdata              peripheral read return (1-cycle pulse)
//   ram_wEn/addr/dataIn, ram_dataOut   RAM port (registered read data)
//   conflict_count                     saturating count of conflict cycles
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_stall,
  input  logic              per_req,
  input  logic              per_we,
  input  logic [ADDR_W-1:0] per_addr,
  input  logic [DATA_W-1:0] per_wdata,
  output logic              per_gnt,
  output logic              per_rvalid,
  output logic [DATA_W-1:0] per_rdata,
  output logic              ram_wEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut,
  output logic [CNT_W-1:0]  conflict_count
);

  logic grant_per;
  logic grant_cpu;
  logic at_max;
  logic wait_inc;
  logic wait_clr;
  logic rd_per;

  // Grants are gated by reset so nothing reaches the RAM or either master
  // while the block is being reset.
  assign grant_per = !reset && per_req && (!cpu_en || at_max);
  assign grant_cpu = !reset && cpu_en && !grant_per;

  assign per_gnt   = grant_per;
  assign cpu_stall = cpu_en && grant_per;

  assign wait_inc = per_req && cpu_en && !grant_per;
  assign wait_clr = grant_per || !per_req;

  arb_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_ctr (
    .clock  (clock),
    .reset  (reset),
    .inc    (wait_inc),
    .clr    (wait_clr),
    .at_max (at_max)
  );

  // RAM port mux. With no grant the CPU fields are still presented (write
  // disabled) so the address path stays steady for the common CPU case.
  always_comb begin
    ram_wEn    = 1'b0;
    ram_addr   = cpu_addr;
    ram_dataIn = cpu_data;
    if (grant_per) begin
      ram_wEn    = per_we;
      ram_addr   = per_addr;
      ram_dataIn = per_wdata;
    end else if (grant_cpu) begin
      ram_wEn    = cpu_wren;
    end
  end

  // Remember that the RAM output next cycle belongs to a peripheral read.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_per <= 1'b0;
    end else begin
      rd_per <= grant_per && !per_we;
    end
  end

  // A read granted just before reset was asserted is dropped, not returned.
  assign per_rvalid = rd_per && !reset;
  assign per_rdata  = ram_dataOut;
  assign cpu_q      = ram_dataOut;

  // Counts every cycle both masters want the RAM, stopping at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      conflict_count <= '0;
    end else if (cpu_en && per_req && (conflict_count != {CNT_W{1'b1}})) begin
      conflict_count <= conflict_count + 1'b1;
    end
  end

endmodule
